// File: rtl/ram_bus_arbiter_if.sv
// One Wishbone port of the shared-RAM bus (8-bit word address, 32-bit data).
// The master drives the cycle; the slave answers with ack/err and read data.
interface ram_bus_arbiter_if;
  localparam int unsigned ADR_W = 8;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

  logic             cyc;
  logic             stb;
  logic             we;
  logic [SEL_W-1:0] sel;
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_w;
  logic [DAT_W-1:0] dat_r;
  logic             ack;
  logic             err;

  modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack, err);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/ram_bus_arbiter.sv
// Round-robin arbiter sharing one RAM Wishbone port between the host and generator masters,
// with a watchdog that aborts unacknowledged RAM accesses with an err pulse.
module ram_bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                    caravel_wb_clk_i,
  input  logic                    caravel_wb_rst_ni,
  ram_bus_arbiter_if.slave        host,
  ram_bus_arbiter_if.slave        gen,
  ram_bus_arbiter_if.master       ram,
  output logic [1:0]              grant_o
);

  localparam int unsigned WD_W = 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic            rr_gen;
  logic [WD_W-1:0] wdog;
  logic            host_req;
  logic            gen_req;
  logic            pick_gen;
  logic            owner_cyc;
  logic            unused_ram_err;

  assign host_req       = host.cyc & host.stb;
  assign gen_req        = gen.cyc & gen.stb;
  // Generator wins when alone, or on a tie when the host was served last.
  assign pick_gen       = gen_req & (~host_req | ~rr_gen);
  assign owner_cyc      = grant_o[1] ? gen.cyc : host.cyc;
  assign unused_ram_err = ram.err;

  always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_ni) begin
    if (!caravel_wb_rst_ni) begin
      state      <= IDLE;
      rr_gen     <= 1'b0;
      wdog       <= '0;
      grant_o    <= '0;
      ram.cyc    <= 1'b0;
      ram.stb    <= 1'b0;
      ram.we     <= 1'b0;
      ram.sel    <= '0;
      ram.adr    <= '0;
      ram.dat_w  <= '0;
      host.ack   <= 1'b0;
      host.err   <= 1'b0;
      host.dat_r <= '0;
      gen.ack    <= 1'b0;
      gen.err    <= 1'b0;
      gen.dat_r  <= '0;
    end else begin
      host.ack <= 1'b0;
      host.err <= 1'b0;
      gen.ack  <= 1'b0;
      gen.err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (host_req | gen_req) begin
            ram.cyc   <= 1'b1;
            ram.stb   <= 1'b1;
            ram.we    <= pick_gen ? gen.we    : host.we;
            ram.sel   <= pick_gen ? gen.sel   : host.sel;
            ram.adr   <= pick_gen ? gen.adr   : host.adr;
            ram.dat_w <= pick_gen ? gen.dat_w : host.dat_w;
            grant_o   <= pick_gen ? 2'b10 : 2'b01;
            rr_gen    <= pick_gen;
            wdog      <= WD_W'(TIMEOUT - 1);
            state     <= BUSY;
          end
        end
        BUSY: begin
          // Priority: ack, then owner abandoning the cycle, then watchdog expiry.
          if (ram.ack) begin
            ram.cyc <= 1'b0;
            ram.stb <= 1'b0;
            if (grant_o[1]) begin
              gen.dat_r <= ram.dat_r;
              gen.ack   <= 1'b1;
            end else begin
              host.dat_r <= ram.dat_r;
              host.ack   <= 1'b1;
            end
            state <= DONE;
          end else if (!owner_cyc) begin
            ram.cyc <= 1'b0;
            ram.stb <= 1'b0;
            grant_o <= '0;
            state   <= IDLE;
          end else if (wdog == '0) begin
            ram.cyc <= 1'b0;
            ram.stb <= 1'b0;
            if (grant_o[1]) gen.err  <= 1'b1;
            else            host.err <= 1'b1;
            state <= DONE;
          end else begin
            wdog <= wdog - WD_W'(1);
          end
        end
        DONE: begin
          grant_o <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Scoreboard bench for ram_bus_arbiter: expected accesses are queued as stimulus is driven
// and retired when the RAM strobe drops.
module tb_ram_bus_arbiter;

  localparam int K_NONE = 0;
  localparam int K_ACK  = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    logic [1:0]  owner;
    logic        we;
    logic [3:0]  sel;
    logic [7:0]  adr;
    logic [31:0] wdat;
    int          kind;
    logic [31:0] rdata;
    int          stb_len;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] grant;

  ram_bus_arbiter_if host_bus ();
  ram_bus_arbiter_if gen_bus ();
  ram_bus_arbiter_if ram_bus ();

  ram_bus_arbiter #(.TIMEOUT(16)) dut (
    .caravel_wb_clk_i  (clk),
    .caravel_wb_rst_ni (rst_n),
    .host              (host_bus),
    .gen               (gen_bus),
    .ram               (ram_bus),
    .grant_o           (grant)
  );

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          host_delay = 1;
  int          gen_delay  = 1;
  logic [31:0] ram_rd = '0;
  logic [31:0] m_host = '0;
  logic [31:0] m_gen  = '0;
  int          cyc_n = 0;
  int          rise_host = 0;
  int          rise_gen  = 0;
  int          fall_none = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] owner, input logic we, input logic [3:0] sel,
                          input logic [7:0] adr, input logic [31:0] wdat, input int kind,
                          input int stb_len);
    exp_t e;
    e.owner = owner; e.we = we; e.sel = sel; e.adr = adr; e.wdat = wdat;
    e.kind = kind; e.rdata = ram_rd; e.stb_len = stb_len;
    sb.push_back(e);
  endtask

  task automatic drive(input bit is_gen, input bit on, input bit we, input logic [3:0] sel,
                       input logic [7:0] adr, input logic [31:0] dat);
    if (is_gen) begin
      gen_bus.cyc = on; gen_bus.stb = on; gen_bus.we = we;
      gen_bus.sel = sel; gen_bus.adr = adr; gen_bus.dat_w = dat;
    end else begin
      host_bus.cyc = on; host_bus.stb = on; host_bus.we = we;
      host_bus.sel = sel; host_bus.adr = adr; host_bus.dat_w = dat;
    end
  endtask

  // Holds a request until ack/err, an optional forced drop, or the wait limit.
  task automatic run_master(input bit is_gen, input bit we, input logic [3:0] sel,
                            input logic [7:0] adr, input logic [31:0] dat, input int drop_after);
    int  n;
    bit  done;
    @(negedge clk);
    drive(is_gen, 1'b1, we, sel, adr, dat);
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (is_gen ? (gen_bus.ack | gen_bus.err) : (host_bus.ack | host_bus.err)) done = 1'b1;
      else if (drop_after != 0 && n >= drop_after) done = 1'b1;
      else if (n >= 64) begin
        check("wait_limit", 64'(n), 64'(63));
        done = 1'b1;
      end
    end
    drive(is_gen, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    m_host = '0;
    m_gen  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // RAM slave model: ack after a per-owner number of strobe cycles (0 = never).
  initial begin
    int rcnt;
    int d;
    rcnt = 0;
    ram_bus.ack = 1'b0;
    ram_bus.err = 1'b0;
    ram_bus.dat_r = '0;
    forever begin
      @(negedge clk);
      ram_bus.dat_r = ram_rd;
      if (ram_bus.stb) begin
        rcnt++;
        d = grant[1] ? gen_delay : host_delay;
        ram_bus.ack = (d != 0 && rcnt == d);
      end else begin
        rcnt = 0;
        ram_bus.ack = 1'b0;
      end
    end
  end

  // Monitor: checks each grant on strobe rise and retires the expectation on strobe fall.
  initial begin
    logic prev_stb;
    bit   after_fall;
    int   stb_len;
    exp_t e;
    prev_stb = 1'b0;
    after_fall = 1'b0;
    stb_len = 0;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (after_fall) begin
        check("pulse_end", 64'({host_bus.ack, host_bus.err, gen_bus.ack, gen_bus.err}), 64'(0));
        check("grant_clear", 64'(grant), 64'(0));
        after_fall = 1'b0;
      end
      if (ram_bus.stb && !prev_stb) begin
        stb_len = 0;
        if (grant[1]) rise_gen = cyc_n;
        else          rise_host = cyc_n;
        if (sb.size() == 0) check("unexpected_grant", 64'(grant), 64'(0));
        else begin
          e = sb[0];
          check("grant", 64'(grant), 64'(e.owner));
          check("ram_cyc", 64'(ram_bus.cyc), 64'(1));
          check("ram_we", 64'(ram_bus.we), 64'(e.we));
          check("ram_sel", 64'(ram_bus.sel), 64'(e.sel));
          check("ram_adr", 64'(ram_bus.adr), 64'(e.adr));
          check("ram_dat", 64'(ram_bus.dat_w), 64'(e.wdat));
        end
      end
      if (ram_bus.stb) stb_len++;
      if (!ram_bus.stb && prev_stb) begin
        if (sb.size() == 0) check("unexpected_end", 64'(stb_len), 64'(0));
        else begin
          e = sb.pop_front();
          if (e.kind == K_ACK) begin
            if (e.owner[1]) m_gen  = e.rdata;
            else            m_host = e.rdata;
          end
          check("resp", 64'({host_bus.ack, host_bus.err, gen_bus.ack, gen_bus.err}),
                64'({!e.owner[1] && e.kind == K_ACK, !e.owner[1] && e.kind == K_ERR,
                     e.owner[1] && e.kind == K_ACK,  e.owner[1] && e.kind == K_ERR}));
          check("host_dat", 64'(host_bus.dat_r), 64'(m_host));
          check("gen_dat", 64'(gen_bus.dat_r), 64'(m_gen));
          check("grant_end", 64'(grant), 64'((e.kind == K_NONE) ? 2'b00 : e.owner));
          if (e.stb_len != 0) check("stb_len", 64'(stb_len), 64'(e.stb_len));
          if (e.kind == K_NONE) fall_none = cyc_n;
          after_fall = (e.kind != K_NONE);
        end
      end
      prev_stb = ram_bus.stb;
    end
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    do_reset();
    check("rst_ctrl", 64'({ram_bus.cyc, ram_bus.stb, ram_bus.we, ram_bus.sel, ram_bus.adr, grant,
                           host_bus.ack, host_bus.err, gen_bus.ack, gen_bus.err}), 64'(0));
    check("rst_dat", 64'({host_bus.dat_r, gen_bus.dat_r}), 64'(0));

    // Host write alone, ack two cycles after strobe
    host_delay = 2;
    ram_rd = 32'hCAFE0001;
    push_exp(2'b01, 1'b1, 4'hF, 8'h05, 32'hA1B2C3D4, K_ACK, 2);
    run_master(1'b0, 1'b1, 4'hF, 8'h05, 32'hA1B2C3D4, 0);
    repeat (2) @(negedge clk);

    // Simultaneous requests after reset: generator first, host three cycles later
    do_reset();
    host_delay = 1;
    gen_delay = 1;
    ram_rd = 32'h0BADF00D;
    push_exp(2'b10, 1'b1, 4'h3, 8'h10, 32'h12345678, K_ACK, 1);
    push_exp(2'b01, 1'b0, 4'hC, 8'h20, 32'h87654321, K_ACK, 1);
    fork
      run_master(1'b1, 1'b1, 4'h3, 8'h10, 32'h12345678, 0);
      run_master(1'b0, 1'b0, 4'hC, 8'h20, 32'h87654321, 0);
    join
    check("grant_spacing", 64'(rise_host - rise_gen), 64'(3));
    repeat (2) @(negedge clk);

    // Generator read; host data must hold
    ram_rd = 32'h11223344;
    push_exp(2'b10, 1'b0, 4'hF, 8'hFF, 32'h0, K_ACK, 1);
    run_master(1'b1, 1'b0, 4'hF, 8'hFF, 32'h0, 0);
    repeat (2) @(negedge clk);

    // Watchdog expiry, then an ack landing in the last allowed cycle
    host_delay = 0;
    ram_rd = 32'hDEADBEEF;
    push_exp(2'b01, 1'b0, 4'hF, 8'h00, 32'h0, K_ERR, 16);
    run_master(1'b0, 1'b0, 4'hF, 8'h00, 32'h0, 0);
    repeat (2) @(negedge clk);
    host_delay = 16;
    ram_rd = 32'h5A5A0F0F;
    push_exp(2'b01, 1'b0, 4'h1, 8'h7E, 32'h0, K_ACK, 16);
    run_master(1'b0, 1'b0, 4'h1, 8'h7E, 32'h0, 0);
    repeat (2) @(negedge clk);

    // Host abandons its cycle while the generator waits
    host_delay = 0;
    gen_delay = 1;
    ram_rd = 32'h99887766;
    push_exp(2'b01, 1'b1, 4'hF, 8'h40, 32'hFFFF0000, K_NONE, 0);
    push_exp(2'b10, 1'b0, 4'h2, 8'h41, 32'h0, K_ACK, 1);
    fork
      run_master(1'b0, 1'b1, 4'hF, 8'h40, 32'hFFFF0000, 4);
      begin
        repeat (2) @(negedge clk);
        run_master(1'b1, 1'b0, 4'h2, 8'h41, 32'h0, 0);
      end
    join
    check("regrant_gap", 64'(rise_gen - fall_none), 64'(1));
    repeat (2) @(negedge clk);

    // Reset in the middle of a generator access
    gen_delay = 0;
    push_exp(2'b10, 1'b1, 4'h8, 8'h33, 32'h01020304, K_NONE, 0);
    fork
      run_master(1'b1, 1'b1, 4'h8, 8'h33, 32'h01020304, 6);
      begin
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        m_host = '0;
        m_gen = '0;
        #1;
        check("async_rst_ctrl", 64'({ram_bus.cyc, ram_bus.stb, ram_bus.we, ram_bus.sel, ram_bus.adr,
                                     grant, host_bus.ack, host_bus.err, gen_bus.ack, gen_bus.err}),
              64'(0));
        check("async_rst_dat", 64'({ram_bus.dat_w, host_bus.dat_r}), 64'(0));
      end
    join
    @(negedge clk);
    rst_n = 1'b1;
    gen_delay = 1;
    ram_rd = 32'h55AA55AA;
    push_exp(2'b10, 1'b0, 4'hF, 8'h66, 32'h0, K_ACK, 1);
    run_master(1'b1, 1'b0, 4'hF, 8'h66, 32'h0, 0);
    repeat (3) @(negedge clk);

    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
